// File: rtl/alu_pkg.sv
// Purpose : shared constants and types for the EX-stage ALU (op classes, funct codes, ALU control).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: alu_op class codes, R-type and SPECIAL2 funct codes, 5-bit aluCtrl_e, 32-bit rotate helper.
package alu_pkg;

  localparam int WIDTH = 32;

  // alu_op classes from the main controller
  localparam logic [4:0] OP_ADD      = 5'b00000;
  localparam logic [4:0] OP_SUB      = 5'b00001;
  localparam logic [4:0] OP_RTYPE    = 5'b00010;
  localparam logic [4:0] OP_AND      = 5'b00011;
  localparam logic [4:0] OP_OR       = 5'b00100;
  localparam logic [4:0] OP_XOR      = 5'b00101;
  localparam logic [4:0] OP_SLT      = 5'b00110;
  localparam logic [4:0] OP_SLTU     = 5'b00111;
  localparam logic [4:0] OP_LUI      = 5'b01000;
  localparam logic [4:0] OP_SPECIAL2 = 5'b01001;
  localparam logic [4:0] OP_SEBSEH   = 5'b01010;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MOVZ  = 6'h0A;
  localparam logic [5:0] FN_MOVN  = 6'h0B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // SPECIAL2 funct codes
  localparam logic [5:0] F2_MADD = 6'h00;
  localparam logic [5:0] F2_MUL  = 6'h02;
  localparam logic [5:0] F2_MSUB = 6'h04;

  // SEB/SEH select carried in the shamt field
  localparam logic [4:0] SH_SEB = 5'b10000;
  localparam logic [4:0] SH_SEH = 5'b11000;

  // Internal ALU control; CTL_ZERO forces a zero result with no side effects
  typedef enum logic [4:0] {
    CTL_ZERO, CTL_ADD, CTL_SUB, CTL_AND, CTL_OR, CTL_XOR, CTL_NOR,
    CTL_SLT, CTL_SLTU, CTL_SLL, CTL_SRL, CTL_SRA, CTL_ROTR,
    CTL_SLLV, CTL_SRLV, CTL_SRAV, CTL_ROTRV, CTL_MOVZ, CTL_MOVN,
    CTL_MFHI, CTL_MFLO, CTL_MTHI, CTL_MTLO, CTL_MULT, CTL_MULTU,
    CTL_MUL, CTL_MADD, CTL_MSUB, CTL_LUI, CTL_SEB, CTL_SEH
  } aluCtrl_e;

  // Rotate right: shift the doubled word so bits leaving at the bottom re-enter at the top
  function automatic logic [31:0] rotr32(input logic [31:0] value, input logic [4:0] amount);
    logic [63:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[31:0];
  endfunction

endpackage

// File: rtl/alu_execute_unit_if.sv
// Purpose : bundles the EX-stage operand/control inputs and the EX/MEM-bound outputs of alu_execute_unit.
// Latency : n/a (wiring only).
// Backpr. : none; the pipeline stalls upstream, this bus has no handshake.
// Ports   : master = pipeline side (drives operands, reads results); slave = alu_execute_unit.
interface alu_execute_unit_if #(
  parameter int WIDTH = 32
);
  logic [4:0]         alu_op;
  logic [5:0]         funct;
  logic [4:0]         shamt;
  logic [4:0]         rs_field;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   pc_plus4;
  logic [WIDTH-1:0]   imm_ext;
  logic               commit;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               reg_write_ok;
  logic               hilo_write;
  logic               mult_op;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   branch_target;

  modport master (
    output alu_op, funct, shamt, rs_field, op_a, op_b, pc_plus4, imm_ext, commit,
    input  result, zero, reg_write_ok, hilo_write, mult_op, product, hi, lo, branch_target
  );

  modport slave (
    input  alu_op, funct, shamt, rs_field, op_a, op_b, pc_plus4, imm_ext, commit,
    output result, zero, reg_write_ok, hilo_write, mult_op, product, hi, lo, branch_target
  );
endinterface

// File: rtl/alu_control_decode.sv
// Purpose : maps (alu_op, funct, shamt, rs_field) to the internal ALU control and HI/LO/multiply flags.
// Latency : combinational.
// Backpr. : none.
// Ports   : in alu_op/funct/shamt/rs_field; out ctrl, hilo_write, mult_op.
module alu_control_decode
  import alu_pkg::*;
(
  input  logic [4:0] alu_op,
  input  logic [5:0] funct,
  input  logic [4:0] shamt,
  input  logic [4:0] rs_field,
  output aluCtrl_e   ctrl,
  output logic       hilo_write,
  output logic       mult_op
);

  // Only rs_field[0] (the ROTR select) carries meaning here
  logic unusedRsBits;
  assign unusedRsBits = ^rs_field[4:1];

  always_comb begin
    ctrl       = CTL_ZERO;
    hilo_write = 1'b0;
    mult_op    = 1'b0;
    case (alu_op)
      OP_ADD:  ctrl = CTL_ADD;
      OP_SUB:  ctrl = CTL_SUB;
      OP_AND:  ctrl = CTL_AND;
      OP_OR:   ctrl = CTL_OR;
      OP_XOR:  ctrl = CTL_XOR;
      OP_SLT:  ctrl = CTL_SLT;
      OP_SLTU: ctrl = CTL_SLTU;
      OP_LUI:  ctrl = CTL_LUI;
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: ctrl = CTL_ADD;
          FN_SUB, FN_SUBU: ctrl = CTL_SUB;
          FN_AND:   ctrl = CTL_AND;
          FN_OR:    ctrl = CTL_OR;
          FN_XOR:   ctrl = CTL_XOR;
          FN_NOR:   ctrl = CTL_NOR;
          FN_SLT:   ctrl = CTL_SLT;
          FN_SLTU:  ctrl = CTL_SLTU;
          FN_SLL:   ctrl = CTL_SLL;
          FN_SRA:   ctrl = CTL_SRA;
          FN_SRL:   ctrl = rs_field[0] ? CTL_ROTR : CTL_SRL;
          FN_SLLV:  ctrl = CTL_SLLV;
          FN_SRAV:  ctrl = CTL_SRAV;
          FN_SRLV:  ctrl = shamt[0] ? CTL_ROTRV : CTL_SRLV;
          FN_MOVZ:  ctrl = CTL_MOVZ;
          FN_MOVN:  ctrl = CTL_MOVN;
          FN_MFHI:  ctrl = CTL_MFHI;
          FN_MFLO:  ctrl = CTL_MFLO;
          FN_MTHI: begin
            ctrl       = CTL_MTHI;
            hilo_write = 1'b1;
          end
          FN_MTLO: begin
            ctrl       = CTL_MTLO;
            hilo_write = 1'b1;
          end
          FN_MULT: begin
            ctrl       = CTL_MULT;
            hilo_write = 1'b1;
          end
          FN_MULTU: begin
            ctrl       = CTL_MULTU;
            hilo_write = 1'b1;
          end
          FN_JR:    ctrl = CTL_ZERO;
          default:  ctrl = CTL_ZERO;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          F2_MUL: begin
            ctrl    = CTL_MUL;
            mult_op = 1'b1;
          end
          F2_MADD: begin
            ctrl       = CTL_MADD;
            hilo_write = 1'b1;
          end
          F2_MSUB: begin
            ctrl       = CTL_MSUB;
            hilo_write = 1'b1;
          end
          default: ctrl = CTL_ZERO;
        endcase
      end
      OP_SEBSEH: begin
        if (shamt == SH_SEB)      ctrl = CTL_SEB;
        else if (shamt == SH_SEH) ctrl = CTL_SEH;
        else                      ctrl = CTL_ZERO;
      end
      default: ctrl = CTL_ZERO;
    endcase
  end

endmodule

// File: rtl/alu_execute_unit.sv
// Purpose : MIPS EX-stage core: ALU control decode, 32-bit ALU, HI/LO pair, branch-target adder.
// Latency : result/flags/product/branch_target combinational; HI/LO update on the Clk edge after a committed write.
// Backpr. : none; a stalled or flushed instruction must arrive with commit=0 so HI/LO hold.
// Ports   : Clk, Reset (async active-low) plain; everything else on bus (alu_execute_unit_if.slave).
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  alu_execute_unit_if.slave bus
);

  aluCtrl_e           ctrl;
  logic               hiloWrite;
  logic               multOp;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [WIDTH-1:0]   hiQ;
  logic [WIDTH-1:0]   loQ;
  logic [WIDTH-1:0]   aluResult;
  logic [2*WIDTH-1:0] signedProd;
  logic [2*WIDTH-1:0] unsignedProd;
  logic [2*WIDTH-1:0] productVal;
  logic [WIDTH-1:0]   immShifted;

  assign opA = bus.op_a;
  assign opB = bus.op_b;

  alu_control_decode uDecode (
    .alu_op     (bus.alu_op),
    .funct      (bus.funct),
    .shamt      (bus.shamt),
    .rs_field   (bus.rs_field),
    .ctrl       (ctrl),
    .hilo_write (hiloWrite),
    .mult_op    (multOp)
  );

  // Operands are explicitly extended to the product width so the low 2*WIDTH bits are exact
  assign signedProd   = {{WIDTH{opA[WIDTH-1]}}, opA} * {{WIDTH{opB[WIDTH-1]}}, opB};
  assign unsignedProd = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};

  always_comb begin
    productVal = signedProd;
    case (ctrl)
      CTL_MULTU: productVal = unsignedProd;
      CTL_MADD:  productVal = {hiQ, loQ} + signedProd;
      CTL_MSUB:  productVal = {hiQ, loQ} - signedProd;
      default:   productVal = signedProd;
    endcase
  end

  always_comb begin
    aluResult = '0;
    case (ctrl)
      CTL_ADD:   aluResult = opA + opB;
      CTL_SUB:   aluResult = opA - opB;
      CTL_AND:   aluResult = opA & opB;
      CTL_OR:    aluResult = opA | opB;
      CTL_XOR:   aluResult = opA ^ opB;
      CTL_NOR:   aluResult = ~(opA | opB);
      CTL_SLT:   aluResult = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
      CTL_SLTU:  aluResult = {{(WIDTH-1){1'b0}}, (opA < opB)};
      CTL_SLL:   aluResult = opB << bus.shamt;
      CTL_SRL:   aluResult = opB >> bus.shamt;
      CTL_SRA:   aluResult = $signed(opB) >>> bus.shamt;
      CTL_ROTR:  aluResult = rotr32(opB, bus.shamt);
      CTL_SLLV:  aluResult = opB << opA[4:0];
      CTL_SRLV:  aluResult = opB >> opA[4:0];
      CTL_SRAV:  aluResult = $signed(opB) >>> opA[4:0];
      CTL_ROTRV: aluResult = rotr32(opB, opA[4:0]);
      CTL_MOVZ,
      CTL_MOVN:  aluResult = opA;
      CTL_MFHI:  aluResult = hiQ;
      CTL_MFLO:  aluResult = loQ;
      CTL_MUL:   aluResult = signedProd[WIDTH-1:0];
      CTL_LUI:   aluResult = {opB[15:0], 16'h0000};
      CTL_SEB:   aluResult = {{(WIDTH-8){opB[7]}}, opB[7:0]};
      CTL_SEH:   aluResult = {{(WIDTH-16){opB[15]}}, opB[15:0]};
      default:   aluResult = '0;
    endcase
  end

  // HI/LO: only committed instructions may write; reset clears without a clock
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hiQ <= '0;
      loQ <= '0;
    end else if (bus.commit && hiloWrite) begin
      case (ctrl)
        CTL_MTHI: hiQ <= opA;
        CTL_MTLO: loQ <= opA;
        default:  {hiQ, loQ} <= productVal;
      endcase
    end
  end

  // Word offset to byte offset; the top two immediate bits fall off, matching 32-bit wrap
  assign immShifted = {bus.imm_ext[WIDTH-3:0], 2'b00};

  logic unusedImmBits;
  assign unusedImmBits = ^bus.imm_ext[WIDTH-1:WIDTH-2];

  assign bus.result        = aluResult;
  assign bus.zero          = (aluResult == '0);
  assign bus.reg_write_ok  = (ctrl == CTL_MOVZ) ? (opB == '0) :
                             (ctrl == CTL_MOVN) ? (opB != '0) : 1'b1;
  assign bus.hilo_write    = hiloWrite;
  assign bus.mult_op       = multOp;
  assign bus.product       = productVal;
  assign bus.hi            = hiQ;
  assign bus.lo            = loQ;
  assign bus.branch_target = bus.pc_plus4 + immShifted;

endmodule

// File: tb/tb_alu_execute_unit.sv
module tb_alu_execute_unit;
  import alu_pkg::*;

  logic clk;
  logic rstN;
  int   errors;
  int   checks;

  alu_execute_unit_if #(.WIDTH(32)) bus ();

  alu_execute_unit #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Reset (rstN),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [4:0] rs);
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.shamt    = sh;
    bus.rs_field = rs;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", bus.lo, 32'h0); end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_add_sub();
    drive(OP_RTYPE, FN_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h80000000) begin errors++; $display("FAIL add_result got %h want %h", bus.result, 32'h80000000); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b want 0", bus.zero); end
    drive(OP_RTYPE, FN_SUB, 32'h5, 32'h5, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL sub_result got %h want %h", bus.result, 32'h0); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b want 1", bus.zero); end
  endtask

  task automatic test_compare_shift();
    drive(OP_RTYPE, FN_SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h1) begin errors++; $display("FAIL slt got %h want %h", bus.result, 32'h1); end
    drive(OP_RTYPE, FN_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL sltu got %h want %h", bus.result, 32'h0); end
    drive(OP_RTYPE, FN_SRA, 32'h0, 32'h80000000, 5'd4, 5'd0);
    #1;
    checks++; if (bus.result !== 32'hF8000000) begin errors++; $display("FAIL sra got %h want %h", bus.result, 32'hF8000000); end
    drive(OP_RTYPE, FN_SRL, 32'h0, 32'h00000001, 5'd1, 5'd1);
    #1;
    checks++; if (bus.result !== 32'h80000000) begin errors++; $display("FAIL rotr got %h want %h", bus.result, 32'h80000000); end
    drive(OP_RTYPE, FN_SRL, 32'h0, 32'h00000001, 5'd1, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL srl got %h want %h", bus.result, 32'h0); end
    drive(OP_RTYPE, FN_SRLV, 32'h4, 32'h000000F1, 5'd1, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h1000000F) begin errors++; $display("FAIL rotrv got %h want %h", bus.result, 32'h1000000F); end
  endtask

  task automatic test_mult_madd();
    @(negedge clk);
    drive(OP_RTYPE, FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0);
    bus.commit = 1'b1;
    #1;
    checks++; if (bus.hilo_write !== 1'b1) begin errors++; $display("FAIL multu_hilo_write got %b want 1", bus.hilo_write); end
    @(posedge clk); #1;
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_hilo got %h want %h", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001); end
    @(negedge clk);
    drive(OP_SPECIAL2, F2_MADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0);
    @(posedge clk); #1;
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000002) begin errors++; $display("FAIL madd_hilo got %h want %h", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000002); end
    @(negedge clk);
    drive(OP_RTYPE, FN_MFHI, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mfhi got %h want %h", bus.result, 32'hFFFFFFFE); end
  endtask

  task automatic test_movz_mul();
    drive(OP_RTYPE, FN_MOVZ, 32'hCAFE0001, 32'h0, 5'd0, 5'd0);
    #1;
    checks++; if (bus.reg_write_ok !== 1'b1) begin errors++; $display("FAIL movz0_rwok got %b want 1", bus.reg_write_ok); end
    checks++; if (bus.result !== 32'hCAFE0001) begin errors++; $display("FAIL movz0_result got %h want %h", bus.result, 32'hCAFE0001); end
    drive(OP_RTYPE, FN_MOVZ, 32'hCAFE0001, 32'h3, 5'd0, 5'd0);
    #1;
    checks++; if (bus.reg_write_ok !== 1'b0) begin errors++; $display("FAIL movz3_rwok got %b want 0", bus.reg_write_ok); end
    drive(OP_RTYPE, FN_MOVN, 32'hCAFE0001, 32'h3, 5'd0, 5'd0);
    #1;
    checks++; if (bus.reg_write_ok !== 1'b1) begin errors++; $display("FAIL movn3_rwok got %b want 1", bus.reg_write_ok); end
    @(negedge clk);
    drive(OP_SPECIAL2, F2_MUL, 32'hFFFFFFFD, 32'h4, 5'd0, 5'd0);
    bus.commit = 1'b1;
    #1;
    checks++; if (bus.result !== 32'hFFFFFFF4) begin errors++; $display("FAIL mul_result got %h want %h", bus.result, 32'hFFFFFFF4); end
    checks++; if (bus.mult_op !== 1'b1) begin errors++; $display("FAIL mul_mult_op got %b want 1", bus.mult_op); end
    checks++; if (bus.hilo_write !== 1'b0) begin errors++; $display("FAIL mul_hilo_write got %b want 0", bus.hilo_write); end
    @(posedge clk); #1;
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000002) begin errors++; $display("FAIL mul_hilo_kept got %h want %h", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000002); end
  endtask

  task automatic test_commit_reset();
    @(negedge clk);
    drive(OP_RTYPE, FN_MTHI, 32'h12345678, 32'h0, 5'd0, 5'd0);
    bus.commit = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mthi_nocommit got %h want %h", bus.hi, 32'hFFFFFFFE); end
    @(negedge clk);
    bus.commit = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.hi !== 32'h12345678) begin errors++; $display("FAIL mthi_commit got %h want %h", bus.hi, 32'h12345678); end
    checks++; if (bus.lo !== 32'h00000002) begin errors++; $display("FAIL mthi_lo_held got %h want %h", bus.lo, 32'h00000002); end
    @(negedge clk);
    drive(OP_RTYPE, FN_MTLO, 32'h0BADF00D, 32'h0, 5'd0, 5'd0);
    @(posedge clk); #1;
    checks++; if ({bus.hi, bus.lo} !== 64'h12345678_0BADF00D) begin errors++; $display("FAIL mtlo got %h want %h", {bus.hi, bus.lo}, 64'h12345678_0BADF00D); end
    @(negedge clk);
    drive(OP_SPECIAL2, F2_MADD, 32'h2, 32'h3, 5'd0, 5'd0);
    #2;
    rstN = 1'b0;
    #1;
    checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL async_reset got %h want %h", {bus.hi, bus.lo}, 64'h0); end
    @(negedge clk);
    rstN = 1'b1;
    bus.commit = 1'b0;
  endtask

  task automatic test_misc();
    drive(OP_LUI, 6'h00, 32'h0, 32'h00001234, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h12340000) begin errors++; $display("FAIL lui got %h want %h", bus.result, 32'h12340000); end
    drive(OP_SEBSEH, 6'h00, 32'h0, 32'h00008001, 5'b11000, 5'd0);
    #1;
    checks++; if (bus.result !== 32'hFFFF8001) begin errors++; $display("FAIL seh got %h want %h", bus.result, 32'hFFFF8001); end
    drive(OP_SEBSEH, 6'h00, 32'h0, 32'h00001280, 5'b10000, 5'd0);
    #1;
    checks++; if (bus.result !== 32'hFFFFFF80) begin errors++; $display("FAIL seb got %h want %h", bus.result, 32'hFFFFFF80); end
    bus.pc_plus4 = 32'h00000100;
    bus.imm_ext  = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.branch_target !== 32'h000000FC) begin errors++; $display("FAIL branch_target got %h want %h", bus.branch_target, 32'h000000FC); end
    drive(5'b11111, 6'h20, 32'h11, 32'h22, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL bad_op_result got %h want %h", bus.result, 32'h0); end
    checks++; if (bus.hilo_write !== 1'b0) begin errors++; $display("FAIL bad_op_hilo got %b want 0", bus.hilo_write); end
    drive(OP_RTYPE, FN_NOR, 32'h0F0F0000, 32'h000000F0, 5'd0, 5'd0);
    #1;
    checks++; if (bus.result !== 32'hF0F0FF0F) begin errors++; $display("FAIL nor got %h want %h", bus.result, 32'hF0F0FF0F); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rstN   = 1'b1;
    drive(OP_ADD, 6'h00, 32'h0, 32'h0, 5'd0, 5'd0);
    bus.pc_plus4 = 32'h0;
    bus.imm_ext  = 32'h0;
    bus.commit   = 1'b0;
    test_reset();
    test_add_sub();
    test_compare_shift();
    test_mult_madd();
    test_movz_mul();
    test_commit_reset();
    test_misc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
